// File: rtl/xcom_qctrl_pkg.sv
// Shared types and constants for the xcom reset/sync request initiator.
package xcom_qctrl_pkg;

    // Handshake phases: idle, request raised, waiting for ack release.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } qctrl_state_e;

    // Command opcodes from the xcom decoder.
    localparam logic [1:0] OP_QRST  = 2'b01;
    localparam logic [1:0] OP_QSYNC = 2'b10;

    // Error codes reported on err_code_o.
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ACK_RISE = 2'b01;
    localparam logic [1:0] ERR_ACK_FALL = 2'b10;
    localparam logic [1:0] ERR_BAD_OP   = 2'b11;

endpackage

// File: rtl/sync_reg.sv
// Two-flop synchronizer for DW-bit quasi-static signals.
module sync_reg #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] dt_i,
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic [DW-1:0] dt_o
);

    logic [DW-1:0] meta_q;
    logic [DW-1:0] sync_q;

    // Shift the input through two flops to settle metastability.
    // NOTE: sequential state is assigned with <= so both flops sample the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= dt_i;
            sync_q <= meta_q;
        end
    end

    assign dt_o = sync_q;

endmodule

// File: rtl/xcom_qctrl_req.sv
// Initiator side of the QICK reset/sync four-phase request handshake.
module xcom_qctrl_req
    import xcom_qctrl_pkg::*;
#(
    parameter int                SYNC_ACK = 0,
    parameter int                TOUT_W   = 16,
    parameter logic [TOUT_W-1:0] TIMEOUT  = 16'd50000,
    parameter int                CNT_W    = 8
) (
    input  logic             t_clk_i,
    input  logic             t_rst_i,
    input  logic             cmd_vld_i,
    input  logic [1:0]       cmd_op_i,
    output logic             cmd_rdy_o,
    output logic             qrst_req_o,
    output logic             qsync_req_o,
    input  logic             qrst_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    localparam logic [TOUT_W-1:0] TOUT_LAST = TIMEOUT - TOUT_W'(1);

    logic ack_s;

    // Ack is either taken as-is (same domain) or resynchronized.
    generate
        if (SYNC_ACK != 0) begin : g_ack_sync
            sync_reg #(.DW(1)) u_ack_sync (
                .dt_i   (qrst_ack_i),
                .clk_i  (t_clk_i),
                .rst_ni (!t_rst_i),
                .dt_o   (ack_s)
            );
        end else begin : g_ack_direct
            assign ack_s = qrst_ack_i;
        end
    endgenerate

    qctrl_state_e      state_q, state_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic              qrst_q, qrst_d;
    logic              qsync_q, qsync_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tout_hit;
    logic              accept;

    // A zero TIMEOUT means wait forever in REQ/REL.
    assign tout_hit  = (TIMEOUT != '0) && (tout_q == TOUT_LAST);
    assign cmd_rdy_o = (state_q == ST_IDLE) && !ack_s;
    assign accept    = cmd_vld_i && cmd_rdy_o;

    // Next-state, request levels, pulses, error code and completion count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        qrst_d  = qrst_q;
        qsync_d = qsync_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d = ERR_NONE;
                    if (cmd_op_i == OP_QRST) begin
                        qrst_d  = 1'b1;
                        state_d = ST_REQ;
                    end else if (cmd_op_i == OP_QSYNC) begin
                        qsync_d = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_BAD_OP;
                    end
                end
            end
            ST_REQ: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (ack_s) begin
                    qrst_d  = 1'b0;
                    qsync_d = 1'b0;
                    state_d = ST_REL;
                end else if (tout_hit) begin
                    qrst_d  = 1'b0;
                    qsync_d = 1'b0;
                    code_d  = ERR_ACK_RISE;
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                    if (code_q == ERR_ACK_RISE) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end else if (tout_hit) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ACK_FALL;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                qrst_d  = 1'b0;
                qsync_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Phase timer restarts on every state change and idles at zero.
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            tout_d = '0;
        end else begin
            tout_d = tout_q + 1'b1;
        end
    end

    // Register all state; reset is synchronous to t_clk_i.
    always_ff @(posedge t_clk_i) begin
        if (t_rst_i) begin
            state_q <= ST_IDLE;
            tout_q  <= '0;
            qrst_q  <= 1'b0;
            qsync_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tout_q  <= tout_d;
            qrst_q  <= qrst_d;
            qsync_q <= qsync_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign qrst_req_o  = qrst_q;
    assign qsync_req_o = qsync_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign done_cnt_o  = cnt_q;

endmodule

// File: tb/tb_xcom_qctrl_req.sv
// Directed bench for xcom_qctrl_req: three instances cover the direct-ack,
// short-timeout and synchronized-ack configurations.
module tb_xcom_qctrl_req;
    import xcom_qctrl_pkg::*;

    logic       t_clk = 1'b0;
    logic       t_rst;
    logic [2:0] cmd_vld;
    logic [1:0] cmd_op [3];
    logic [2:0] ack;
    logic [2:0] cmd_rdy;
    logic [2:0] qrst_req;
    logic [2:0] qsync_req;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] err;
    logic [1:0] err_code [3];
    logic [7:0] done_cnt [3];

    int n_chk = 0;
    int n_err = 0;

    // Per-handshake observations filled in by run_hs.
    int r_qrst, r_qsync, r_done, r_err, r_busy, r_bound, r_end_done;

    always #5 t_clk = ~t_clk;

    // Instance 0: direct ack, TIMEOUT 1000.
    xcom_qctrl_req #(.SYNC_ACK(0), .TOUT_W(16), .TIMEOUT(16'd1000), .CNT_W(8)) u_dut_a (
        .t_clk_i(t_clk), .t_rst_i(t_rst), .cmd_vld_i(cmd_vld[0]), .cmd_op_i(cmd_op[0]),
        .cmd_rdy_o(cmd_rdy[0]), .qrst_req_o(qrst_req[0]), .qsync_req_o(qsync_req[0]),
        .qrst_ack_i(ack[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
        .err_code_o(err_code[0]), .done_cnt_o(done_cnt[0])
    );

    // Instance 1: direct ack, TIMEOUT 16.
    xcom_qctrl_req #(.SYNC_ACK(0), .TOUT_W(16), .TIMEOUT(16'd16), .CNT_W(8)) u_dut_t (
        .t_clk_i(t_clk), .t_rst_i(t_rst), .cmd_vld_i(cmd_vld[1]), .cmd_op_i(cmd_op[1]),
        .cmd_rdy_o(cmd_rdy[1]), .qrst_req_o(qrst_req[1]), .qsync_req_o(qsync_req[1]),
        .qrst_ack_i(ack[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
        .err_code_o(err_code[1]), .done_cnt_o(done_cnt[1])
    );

    // Instance 2: synchronized ack, TIMEOUT 1000.
    xcom_qctrl_req #(.SYNC_ACK(1), .TOUT_W(16), .TIMEOUT(16'd1000), .CNT_W(8)) u_dut_s (
        .t_clk_i(t_clk), .t_rst_i(t_rst), .cmd_vld_i(cmd_vld[2]), .cmd_op_i(cmd_op[2]),
        .cmd_rdy_o(cmd_rdy[2]), .qrst_req_o(qrst_req[2]), .qsync_req_o(qsync_req[2]),
        .qrst_ack_i(ack[2]), .busy_o(busy[2]), .done_o(done[2]), .err_o(err[2]),
        .err_code_o(err_code[2]), .done_cnt_o(done_cnt[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [1:0] op);
        cmd_op[i]  = op;
        cmd_vld[i] = 1'b1;
        tick();
        cmd_vld[i] = 1'b0;
    endtask

    // Issue a command and play the responder: ack rises once the request has
    // been seen high for rise+1 cycles, falls once the request has been seen
    // low for fall+1 cycles; a negative delay means never.
    task automatic run_hs(input int i, input logic [1:0] op, input int rise, input int fall);
        int hi;
        int lo;
        hi = 0; lo = 0;
        r_qrst = 0; r_qsync = 0; r_done = 0; r_err = 0; r_busy = 0;
        r_bound = 1; r_end_done = 0;
        issue(i, op);
        for (int c = 0; c < 5000; c++) begin
            if (qrst_req[i])  r_qrst++;
            if (qsync_req[i]) r_qsync++;
            if (done[i])      r_done++;
            if (err[i])       r_err++;
            if (!busy[i]) begin
                r_bound    = 0;
                r_end_done = int'(done[i]);
                break;
            end
            r_busy++;
            if (qrst_req[i] || qsync_req[i]) begin
                hi++;
                if (rise >= 0 && hi == rise + 1) ack[i] = 1'b1;
            end else if (hi > 0 && ack[i]) begin
                lo++;
                if (fall >= 0 && lo == fall + 1) ack[i] = 1'b0;
            end
            tick();
        end
        check("hs_cycle_bound_expired", r_bound, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t_rst   = 1'b1;
        cmd_vld = '0;
        ack     = '0;
        for (int i = 0; i < 3; i++) cmd_op[i] = 2'b00;
        repeat (3) tick();

        // Reset state of every instance.
        for (int i = 0; i < 3; i++) begin
            check("rst_rdy",   cmd_rdy[i], 1);
            check("rst_req",   {qrst_req[i], qsync_req[i]}, 0);
            check("rst_busy",  busy[i], 0);
            check("rst_pulse", {done[i], err[i]}, 0);
            check("rst_code",  err_code[i], 0);
            check("rst_cnt",   done_cnt[i], 0);
        end
        t_rst = 1'b0;
        tick();

        // QRST nominal: request 2 cycles, 4 busy cycles, done at busy drop.
        run_hs(0, OP_QRST, 1, 1);
        check("nom_req_cycles",  r_qrst, 2);
        check("nom_qsync_never", r_qsync, 0);
        check("nom_busy_cycles", r_busy, 4);
        check("nom_done_count",  r_done, 1);
        check("nom_done_at_end", r_end_done, 1);
        check("nom_cnt",         done_cnt[0], 1);
        check("nom_code",        err_code[0], ERR_NONE);
        tick();
        check("nom_done_pulse",  done[0], 0);

        // QSYNC with ack 300 cycles after the request.
        run_hs(0, OP_QSYNC, 300, 1);
        check("qsync_req_cycles", r_qsync, 301);
        check("qsync_qrst_never", r_qrst, 0);
        check("qsync_busy",       r_busy, 303);
        check("qsync_done",       r_done, 1);
        check("qsync_code",       err_code[0], ERR_NONE);
        check("qsync_cnt",        done_cnt[0], 2);

        // Invalid op: error pulse, code 11, no request, count unchanged.
        issue(0, 2'b11);
        check("bad_err",  err[0], 1);
        check("bad_code", err_code[0], ERR_BAD_OP);
        check("bad_busy", busy[0], 0);
        check("bad_req",  {qrst_req[0], qsync_req[0]}, 0);
        tick();
        check("bad_err_pulse", err[0], 0);
        check("bad_code_held", err_code[0], ERR_BAD_OP);
        check("bad_cnt",       done_cnt[0], 2);

        // Ack-rise timeout with TIMEOUT 16.
        run_hs(1, OP_QRST, -1, -1);
        check("rto_req_cycles", r_qrst, 16);
        check("rto_busy",       r_busy, 17);
        check("rto_err",        r_err, 1);
        check("rto_done",       r_done, 0);
        check("rto_code",       err_code[1], ERR_ACK_RISE);
        check("rto_rdy",        cmd_rdy[1], 1);
        check("rto_cnt",        done_cnt[1], 0);

        // Ack stuck high: fall timeout, then commands ignored until release.
        run_hs(1, OP_QSYNC, 1, -1);
        check("stk_req_cycles", r_qsync, 2);
        check("stk_busy",       r_busy, 18);
        check("stk_err",        r_err, 1);
        check("stk_code",       err_code[1], ERR_ACK_FALL);
        check("stk_rdy_low",    cmd_rdy[1], 0);
        issue(1, OP_QRST);
        check("stk_ignored_req",  qrst_req[1], 0);
        check("stk_ignored_busy", busy[1], 0);
        check("stk_code_kept",    err_code[1], ERR_ACK_FALL);
        ack[1] = 1'b0;
        tick();
        check("stk_rdy_release", cmd_rdy[1], 1);

        // Reset during REQ drops the request at the next edge.
        issue(0, OP_QRST);
        tick();
        check("rreq_req_up", qrst_req[0], 1);
        t_rst  = 1'b1;
        ack[0] = 1'b1;
        tick();
        check("rreq_req_low", qrst_req[0], 0);
        check("rreq_busy",    busy[0], 0);
        check("rreq_cnt",     done_cnt[0], 0);
        check("rreq_code",    err_code[0], ERR_NONE);
        check("rreq_rdy_ack", cmd_rdy[0], 0);
        t_rst  = 1'b0;
        tick();
        check("rreq_rdy_wait", cmd_rdy[0], 0);
        ack[0] = 1'b0;
        tick();
        check("rreq_rdy_back", cmd_rdy[0], 1);

        // Synchronized ack: each phase two cycles longer.
        run_hs(2, OP_QRST, 1, 1);
        check("sync_req_cycles", r_qrst, 4);
        check("sync_busy",       r_busy, 8);
        check("sync_done",       r_done, 1);
        check("sync_cnt",        done_cnt[2], 1);

        // 256 back-to-back nominal QRSTs wrap the 8-bit counter to zero.
        for (int n = 0; n < 256; n++) begin
            run_hs(0, OP_QRST, 1, 1);
            if (n == 0)   check("wrap_first_cnt", done_cnt[0], 1);
            if (n == 254) check("wrap_max_cnt",   done_cnt[0], 255);
        end
        check("wrap_cnt_zero", done_cnt[0], 0);
        check("wrap_code",     err_code[0], ERR_NONE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/xcom_qctrl_req.md
# xcom_qctrl_req

Initiator side of the QICK reset/sync request handshake. It accepts a one-cycle command from the xcom command decoder and drives a level request, `qrst_req_o` or `qsync_req_o`, toward the tProc reset responder. It then runs a four-phase handshake against the responder's `qrst_ack_i`, with per-phase timeouts, and reports completion or error back to the decoder.

## Interface
Parameters:
- `SYNC_ACK`, 0 — 1 routes `qrst_ack_i` through a 2-flop synchronizer; 0 samples it directly (same clock domain).
- `TOUT_W`, 16 — width of the timeout counter.
- `TIMEOUT`, 16'd50000 — cycles allowed per handshake phase; 0 disables timeouts.
- `CNT_W`, 8 — width of the completed-command counter.

Ports:
- `t_clk_i`  in  1  — clock, the single clock.
- `t_rst_i`  in  1  — reset, synchronous, active-high.
- `cmd_vld_i`  in  1  — one-cycle command strobe from the decoder.
- `cmd_op_i`  in  2  — 2'b01 QRST, 2'b10 QSYNC; 2'b00 and 2'b11 are invalid.
- `cmd_rdy_o`  out  1  — block can accept a command.
- `qrst_req_o`  out  1  — reset request level, registered.
- `qsync_req_o`  out  1  — sync-then-reset request level, registered.
- `qrst_ack_i`  in  1  — acknowledge from the responder.
- `busy_o`  out  1  — state is not IDLE.
- `done_o`  out  1  — one-cycle pulse on successful handshake completion.
- `err_o`  out  1  — one-cycle error pulse.
- `err_code_o`  out  2  — 00 none, 01 ack-rise timeout, 10 ack-fall timeout, 11 invalid op; held until the next accepted command.
- `done_cnt_o`  out  CNT_W  — count of successful handshakes; wraps.

## Operation
States:
- **IDLE**
  - `cmd_rdy_o` = IDLE & !ack_s, where ack_s is the sampled ack.
  - Accept = `cmd_vld_i` & `cmd_rdy_o`. `cmd_vld_i` while not ready is dropped silently.
  - On accept, clear `err_code_o`.
  - Op 01: set `qrst_req_o`, go to REQ.
  - Op 10: set `qsync_req_o`, go to REQ.
  - Invalid op: stay in IDLE, pulse `err_o`, set `err_code_o` = 11.
- **REQ** — hold the request and wait for ack_s = 1.
  - On ack_s = 1: clear both requests, go to REL.
  - On timeout: clear both requests, latch err_code 01, go to REL.
- **REL** — wait for ack_s = 0.
  - On ack_s = 0 with no error latched: pulse `done_o`, increment `done_cnt_o`, go to IDLE.
  - On ack_s = 0 with err 01 latched: pulse `err_o`, go to IDLE.
  - On timeout: pulse `err_o`, err_code = 10 (overrides 01), go to IDLE.

Only one request output is high at a time; both are 0 outside REQ.

Timeout counter:
- Cleared on entry to REQ and REL.
- Increments each cycle in those states.
- Timeout asserts when the count reaches TIMEOUT-1 and the exit condition is not met.
- If ack condition and timeout occur in the same cycle, the ack wins.
- With TIMEOUT = 0 the block never times out.

A QSYNC request may legitimately wait for an external sync pulse. TIMEOUT must exceed the sync-pulse period.

## Timing
- Reset: state IDLE; all outputs 0 except `cmd_rdy_o`, which is 1 if ack_s = 0. Timeout counter, `done_cnt_o` and `err_code_o` reset to 0.
- Reset mid-handshake drops the request at the next edge. After reset the block waits in IDLE with `cmd_rdy_o` low until ack falls.
- Accept at edge k → request high from cycle k+1.
- Latency from ack_s to output: ack_s high at edge m → request low at m+1. ack_s low at edge n → `done_o` high for cycle n+1 and `busy_o` low from n+1.
- SYNC_ACK = 1 adds 2 cycles of ack latency to each transition.
- Earliest next accept: the cycle `done_o` is high, provided ack_s = 0.
- `done_cnt_o` wraps from 2^CNT_W−1 to 0 without a flag.

## Structure
- Package `xcom_qctrl_pkg` holds:
  - state enum (IDLE, REQ, REL)
  - op constants (OP_QRST = 2'b01, OP_QSYNC = 2'b10)
  - error-code constants
- Sub-module: reuse `sync_reg` (DW = 1) for the ack synchronizer when SYNC_ACK = 1, with `rst_ni` driven by `!t_rst_i`.
- Everything else lives in one always_ff block plus next-state comb logic.

## Test plan
- **QRST nominal** (SYNC_ACK=0): op 01. Responder acks 1 cycle after the request and drops ack 1 cycle after the request falls. Expect `qrst_req_o` high for exactly 2 cycles, one `done_o`, `done_cnt_o` = 1, `qsync_req_o` never high.
- **QSYNC with delayed ack**: op 10, ack arrives 300 cycles later (TIMEOUT = 1000). Expect `qsync_req_o` high for 301 cycles, then `done_o`, err_code 00.
- **Ack-rise timeout**: TIMEOUT = 16, ack never rises. Expect the request to drop after 16 cycles in REQ, then `err_o` pulse with err_code 01, and `cmd_rdy_o` = 1 afterward.
- **Ack stuck high**: ack stays 1 after the request drops, TIMEOUT = 16. Expect `err_o` with err_code 10. Then `cmd_rdy_o` stays 0 until ack is released, and a command issued meanwhile is ignored.
- **Invalid op and wrap**: op 11 → `err_o` with code 11, no request. Next, 256 nominal QRSTs with CNT_W = 8 → `done_cnt_o` = 0.
- **Reset and SYNC_ACK**: assert `t_rst_i` during REQ → request low the next cycle. Repeat the nominal case with SYNC_ACK = 1 → each phase is 2 cycles longer.
